// File: rtl/simon_pkg.sv
// Shared types and constants for the SIMON bit-serial core controller.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_PT,
    ST_RUN,
    ST_UNLOAD,
    ST_HOLD
  } state_t;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_PT   = 2'b01;
  localparam logic [1:0] MODE_KEY  = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  localparam int DEF_BLOCK_W = 128;
  localparam int DEF_KEY_W   = 128;
  localparam int DEF_TIMEOUT = 8191;

endpackage

// File: rtl/simon_piso_sipo.sv
// Shift register shared by the key, plaintext and ciphertext paths: parallel
// load, right shift with serial input entering at the MSB.
module simon_piso_sipo #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {serial_in, data[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/simon_serial_ctrl.sv
// Feeds key and plaintext bit-serially into a SIMON core, collects the serial
// ciphertext and presents it on a valid/ready port, with a RUN-phase watchdog.
module simon_serial_ctrl #(
  parameter int BLOCK_W = simon_pkg::DEF_BLOCK_W,
  parameter int KEY_W   = simon_pkg::DEF_KEY_W,
  parameter int TIMEOUT = simon_pkg::DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [KEY_W-1:0]   key,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy,
  output logic               err,
  output logic               core_data_in,
  output logic [1:0]         core_data_rdy,
  output logic               core_debug,
  input  logic               core_cipher_out,
  input  logic               core_valid
);
  import simon_pkg::*;

  localparam int SR_W  = (BLOCK_W > KEY_W) ? BLOCK_W : KEY_W;
  localparam int CNT_W = $clog2(SR_W) + 1;
  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] KEY_LAST    = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] PT_LAST     = CNT_W'(BLOCK_W - 1);
  localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(BLOCK_W - 2);
  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(TIMEOUT - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RUN_W-1:0]   run_cnt, run_cnt_n;
  logic               key_loaded, key_loaded_n;
  logic               err_n, data_in_n;
  logic [1:0]         mode_n;
  logic [BLOCK_W-1:0] out_block_n;
  logic               sr_load, sr_shift, sr_sin;
  logic [SR_W-1:0]    sr_ldata, sr, key_ext, pt_ext;

  assign key_ext    = SR_W'(key);
  assign pt_ext     = SR_W'(in_block);
  assign core_debug = 1'b0;

  // The register holds the bits still to be sent; the bit on the wire lives in
  // core_data_in, so a load stores the word already shifted by one.
  simon_piso_sipo #(.DATA_W(SR_W)) u_sr (
    .clk       (clk),
    .load      (sr_load),
    .load_data (sr_ldata),
    .shift     (sr_shift),
    .serial_in (sr_sin),
    .data      (sr)
  );

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    run_cnt_n    = run_cnt;
    key_loaded_n = key_loaded;
    err_n        = 1'b0;
    mode_n       = core_data_rdy;
    data_in_n    = 1'b0;
    out_block_n  = out_block;
    sr_load      = 1'b0;
    sr_ldata     = '0;
    sr_shift     = 1'b0;
    sr_sin       = 1'b0;
    case (state)
      ST_IDLE: begin
        mode_n = MODE_IDLE;
        if (key_valid && key_ready) begin
          sr_load   = 1'b1;
          sr_ldata  = {1'b0, key_ext[SR_W-1:1]};
          data_in_n = key_ext[0];
          cnt_n     = '0;
          mode_n    = MODE_KEY;
          state_n   = ST_LOAD_KEY;
        end else if (in_valid && in_ready) begin
          if (key_loaded) begin
            sr_load   = 1'b1;
            sr_ldata  = {1'b0, pt_ext[SR_W-1:1]};
            data_in_n = pt_ext[0];
            cnt_n     = '0;
            mode_n    = MODE_PT;
            state_n   = ST_LOAD_PT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_LOAD_KEY: begin
        if (cnt == KEY_LAST) begin
          key_loaded_n = 1'b1;
          mode_n       = MODE_IDLE;
          state_n      = ST_IDLE;
        end else begin
          sr_shift  = 1'b1;
          data_in_n = sr[0];
          cnt_n     = cnt + 1'b1;
        end
      end
      ST_LOAD_PT: begin
        if (cnt == PT_LAST) begin
          cnt_n     = '0;
          run_cnt_n = '0;
          mode_n    = MODE_RUN;
          state_n   = ST_RUN;
        end else begin
          sr_shift  = 1'b1;
          data_in_n = sr[0];
          cnt_n     = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (core_valid) begin
          sr_shift = 1'b1;
          sr_sin   = core_cipher_out;
          cnt_n    = '0;
          state_n  = ST_UNLOAD;
        end else if (run_cnt == RUN_LAST) begin
          err_n        = 1'b1;
          key_loaded_n = 1'b0;
          mode_n       = MODE_IDLE;
          state_n      = ST_IDLE;
        end else begin
          run_cnt_n = run_cnt + 1'b1;
        end
      end
      ST_UNLOAD: begin
        sr_shift = 1'b1;
        sr_sin   = core_cipher_out;
        if (cnt == UNLOAD_LAST) begin
          out_block_n = {core_cipher_out, sr[SR_W-1 -: BLOCK_W-1]};
          mode_n      = MODE_IDLE;
          state_n     = ST_HOLD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        mode_n  = MODE_IDLE;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      run_cnt       <= '0;
      key_loaded    <= 1'b0;
      err           <= 1'b0;
      core_data_rdy <= MODE_IDLE;
      core_data_in  <= 1'b0;
      out_block     <= '0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      key_ready     <= 1'b0;
      in_ready      <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      run_cnt       <= run_cnt_n;
      key_loaded    <= key_loaded_n;
      err           <= err_n;
      core_data_rdy <= mode_n;
      core_data_in  <= data_in_n;
      out_block     <= out_block_n;
      out_valid     <= (state_n == ST_HOLD);
      busy          <= (state_n != ST_IDLE);
      key_ready     <= (state_n == ST_IDLE);
      in_ready      <= (state_n == ST_IDLE);
    end
  end

endmodule
